// File: rtl/s2_cfg_pkg.sv
// Shared definitions for the s2 configuration loader: cell layout and FSM state encoding.
package s2_cfg_pkg;

  localparam int CELL_CFG_W = 8;

  // Bit positions inside one cell configuration byte {D3,D2,D1,D0,A1,B1,A0,B0}.
  localparam int B0_POS = 0;
  localparam int A0_POS = 1;
  localparam int B1_POS = 2;
  localparam int A1_POS = 3;
  localparam int D0_POS = 4;
  localparam int D1_POS = 5;
  localparam int D2_POS = 6;
  localparam int D3_POS = 7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] d;
    logic       a1;
    logic       b1;
    logic       a0;
    logic       b0;
  } cell_cfg_t;

endpackage

// File: rtl/s2_cfg_shreg.sv
// Left-shifting shadow register: new bits enter at the LSB, so the first bit ends up at the MSB.
module s2_cfg_shreg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         shift_en,
  input  logic         bit_in,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (shift_en) begin
      q_d = {q_q[W-2:0], bit_in};
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/s2_cfg_loader.sv
// Serial configuration loader for NCELL s2 logic cells; the stream is committed only if it checks out.
// Optional even-parity trailer bit is enabled by defining S2_CFG_PARITY_EN.
module s2_cfg_loader
  import s2_cfg_pkg::*;
#(
  parameter int NCELL = 4
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        start,
  input  logic                        bit_in,
  input  logic                        bit_valid,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic                        cfg_we,
  output logic [NCELL*CELL_CFG_W-1:0] cfg_out,
  output state_t                      dbg_state_o
);

  localparam int DATA_W = NCELL * CELL_CFG_W;
  localparam int CNT_W  = $clog2(DATA_W + 1);
`ifdef S2_CFG_PARITY_EN
  localparam int STREAM_W = DATA_W + 1;
`else
  localparam int STREAM_W = DATA_W;
`endif
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(STREAM_W - 1);
  localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(DATA_W);

  state_t              state_q;
  state_t              state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [DATA_W-1:0]   cfg_q;
  logic [DATA_W-1:0]   cfg_d;
  logic [DATA_W-1:0]   shadow;
  logic                accept;
  logic                last_bit;
  logic                load_entry;
  logic                shift_en;
  logic                pass;

  // A bit is consumed only on an edge where bit_valid=1 and the FSM is in LOAD;
  // there is no back-pressure, so bit_valid acts as a one-sided strobe.
  assign accept     = (state_q == S_LOAD) && bit_valid;
  assign last_bit   = accept && (cnt_q == LAST_IDX);
  assign load_entry = (state_q == S_IDLE) && start;
  assign shift_en   = accept && (cnt_q < DATA_CNT);

  s2_cfg_shreg #(
    .W(DATA_W)
  ) u_shreg (
    .clk     (clk),
    .clr     (clr | load_entry),
    .shift_en(shift_en),
    .bit_in  (bit_in),
    .q       (shadow)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  if (last_bit) state_d = S_CHECK;
      S_CHECK: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q == S_LOAD) || (state_q == S_CHECK);
    done   = (state_q == S_DONE);
    cfg_we = (state_q == S_DONE) && !err;
  end

  // The counter holds on the final bit so it never wraps within a stream.
  always_comb begin
    cnt_d = cnt_q;
    if (load_entry) begin
      cnt_d = '0;
    end else if (accept && !last_bit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef S2_CFG_PARITY_EN
  logic par_q;
  logic par_d;
  logic err_q;
  logic err_d;

  // Accumulating data and parity bits together leaves 0 for a well-formed even-parity stream.
  always_comb begin
    par_d = par_q;
    if (load_entry) begin
      par_d = 1'b0;
    end else if (accept) begin
      par_d = par_q ^ bit_in;
    end
  end

  assign pass = ~par_q;

  always_comb begin
    err_d = err_q;
    if (load_entry) begin
      err_d = 1'b0;
    end else if ((state_q == S_CHECK) && !pass) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      par_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      par_q <= par_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign pass = 1'b1;
  assign err  = 1'b0;
`endif

  always_comb begin
    cfg_d = cfg_q;
    if ((state_q == S_CHECK) && pass) begin
      cfg_d = shadow;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cfg_q <= '0;
    end else begin
      cfg_q <= cfg_d;
    end
  end

  assign cfg_out     = cfg_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_s2_cfg_loader.sv
// Bench for s2_cfg_loader (NCELL=2): directed scenarios plus randomized streams against a stream-level model.
module tb_s2_cfg_loader;
  import s2_cfg_pkg::*;

  localparam int NCELL = 2;
  localparam int DW    = NCELL * CELL_CFG_W;
`ifdef S2_CFG_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int NB = DW + (PAR_EN ? 1 : 0);

  logic          clk = 1'b0;
  logic          clr;
  logic          start;
  logic          bit_in;
  logic          bit_valid;
  logic          busy;
  logic          done;
  logic          err;
  logic          cfg_we;
  logic [DW-1:0] cfg_out;
  state_t        dbg_state;

  s2_cfg_loader #(
    .NCELL(NCELL)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cfg_we     (cfg_we),
    .cfg_out    (cfg_out),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int            tests = 0;
  int            fails = 0;
  logic [DW+1:0] exp_q[$];   // {cfg_out, err, cfg_we} expected at each done pulse
  logic [DW-1:0] model_cfg;
  logic          model_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream-level reference: a stream commits iff its parity trailer (when present) matches.
  task automatic model_stream(input logic [DW-1:0] d, input logic par);
    logic ok;
    ok = !PAR_EN || ((^d) == par);
    if (ok) model_cfg = d;
    model_err = !ok;
    exp_q.push_back({model_cfg, model_err, ok});
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic          prev_done;
    logic [DW+1:0] e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (cfg_we) chk("cfg_we_with_done", done, 1);
      if (done) begin
        chk("done_single_cycle", prev_done, 0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1 expected no completion at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("cfg_out_at_done", cfg_out, e[DW+1:2]);
          chk("err_at_done", err, e[1]);
          chk("cfg_we_at_done", cfg_we, e[0]);
        end
      end
      prev_done = done;
    end
  end

  // ---------------- driver ----------------
  task automatic send_stream(input logic [DW-1:0] d, input logic par, input int gap_max,
                             input int stall_at, input int stall_len,
                             input int ign_start_at, input bit start_with_bit);
    bit stall_ok;
    int lat;
    stall_ok = 1'b1;
    lat = 0;
    model_stream(d, par);
    start     = 1'b1;
    bit_valid = start_with_bit;
    bit_in    = ~d[DW-1];
    @(posedge clk); #1;
    start     = 1'b0;
    bit_valid = 1'b0;
    chk("err_cleared_on_start", err, 0);
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < NB; i++) begin
      if (i == stall_at) begin
        repeat (stall_len) begin
          @(posedge clk); #1;
          if (!busy) stall_ok = 1'b0;
        end
      end
      if (i == ign_start_at) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          @(posedge clk); #1;
        end
      end
      bit_in    = (i < DW) ? d[DW-1-i] : par;
      bit_valid = 1'b1;
      @(posedge clk); #1;
      bit_valid = 1'b0;
      bit_in    = 1'($urandom);
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("done_latency", lat, 2);
    if (stall_len > 0) chk("busy_during_stall", stall_ok, 1);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stimulus
    logic [DW-1:0] d;
    logic          p;
    clr       = 1'b1;
    start     = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    model_cfg = '0;
    model_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cfg_we", cfg_we, 0);
    chk("rst_cfg_out", cfg_out, 0);
    chk("rst_state", dbg_state, S_IDLE);
    clr = 1'b0;
    @(posedge clk); #1;

    // Pass load
    send_stream(16'hA53C, 1'b0, 0, -1, 0, -1, 1'b0);
    chk("pass_cfg_out", cfg_out, model_cfg);

    // Parity fail (passes when the parity trailer is not compiled in)
    send_stream(16'h0001, 1'b0, 0, -1, 0, -1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("err_held", err, model_err);
    chk("cfg_out_kept", cfg_out, model_cfg);

    // Stall mid-stream
    send_stream(16'hA53C, 1'b0, 0, 8, 5, -1, 1'b0);
    chk("stall_cfg_out", cfg_out, model_cfg);

    // Ignored inputs: bit_valid in IDLE, start during LOAD, start with first bit_valid
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'($urandom);
      @(posedge clk); #1;
      chk("idle_bit_ignored_state", dbg_state, S_IDLE);
      chk("idle_bit_ignored_busy", busy, 0);
    end
    bit_valid = 1'b0;
    d = 16'h5A96;
    send_stream(d, ^d, 0, -1, 0, 5, 1'b1);
    chk("ignored_inputs_cfg_out", cfg_out, model_cfg);

    // Reset mid-load after 7 bits
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bit_in    = 1'($urandom);
      bit_valid = 1'b1;
      @(posedge clk); #1;
    end
    bit_valid = 1'b0;
    clr       = 1'b1;
    @(posedge clk); #1;
    clr       = 1'b0;
    model_cfg = '0;
    chk("midload_clr_busy", busy, 0);
    chk("midload_clr_cfg_out", cfg_out, 0);
    chk("midload_clr_state", dbg_state, S_IDLE);
    d = 16'hFF00;
    send_stream(d, ^d, 0, -1, 0, -1, 1'b0);
    chk("after_clr_cfg_out", cfg_out, model_cfg);

    // Randomized streams with random gaps and occasional bad parity
    for (int n = 0; n < 20; n++) begin
      d = DW'($urandom);
      p = (^d) ^ ($urandom_range(0, 3) == 0);
      send_stream(d, p, $urandom_range(0, 3), -1, 0, -1, 1'($urandom_range(0, 1)));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/s2_cfg_loader.md
S2_CFG_LOADER -- requirements
Module: s2_cfg_loader

Interface
REQ-001 Parameter NCELL, default 4: number of s2 logic cells configured per stream.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 clr  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  one-cycle request to begin a configuration stream.
REQ-005 bit_in  input  1  serial configuration bit.
REQ-006 bit_valid  input  1  bit_in is accepted on an edge where bit_valid=1 and state=LOAD.
REQ-007 busy  output  1  high in LOAD and CHECK.
REQ-008 done  output  1  one-cycle pulse on stream completion, pass or fail.
REQ-009 err  output  1  stream failed its check; held until the next start or clr.
REQ-010 cfg_we  output  1  one-cycle pulse when cfg_out takes a new value.
REQ-011 cfg_out  output  NCELL*8  committed configuration; cell k = cfg_out[8k+7:8k] = {D3,D2,D1,D0,A1,B1,A0,B0}.

Function
REQ-012 FSM states: IDLE, LOAD, CHECK, DONE.
REQ-013 IDLE->LOAD on start=1; entry clears the bit counter, the shadow register and err.
REQ-014 In LOAD, each accepted bit shifts into the shadow register LSB, shifting left, so the first bit lands in cfg_out[NCELL*8-1] (stream MSB-first).
REQ-015 bit_valid=0 in LOAD stalls the FSM with no time-out.
REQ-016 LOAD->CHECK on the edge that accepts the final stream bit: NCELL*8 data bits, plus one parity bit when the parity feature is compiled in.
REQ-017 CHECK lasts one cycle and always goes to DONE; on pass, the exit edge copies shadow to cfg_out; on fail, cfg_out keeps its prior value and err is set.
REQ-018 DONE lasts one cycle, asserts done, asserts cfg_we only on pass, then goes to IDLE.
REQ-019 Latency: done is high in the second cycle after the edge that samples the final bit.
REQ-020 start while busy or in DONE is ignored; bit_valid in IDLE or DONE is ignored.
REQ-021 start and the first bit_valid in the same cycle: that bit is not accepted, because acceptance requires state=LOAD.
REQ-022 The bit counter width is clog2(NCELL*8+1) and the counter does not wrap within a stream.

Reset
REQ-023 clr=1 on an edge forces IDLE from any state, including mid-LOAD or CHECK, and overrides all other inputs.
REQ-024 Reset values: busy=0, done=0, err=0, cfg_we=0, cfg_out=0, shadow=0, counter=0.

Configuration
REQ-025 Macro S2_CFG_PARITY_EN defined: one even-parity bit follows the data bits; CHECK fails when the XOR of the NCELL*8 data bits differs from the parity bit.
REQ-026 Macro S2_CFG_PARITY_EN undefined: no parity bit is expected, CHECK always passes, and err is constant 0.

Structure
REQ-027 Shared package s2_cfg_pkg holds CELL_CFG_W=8, the cell field bit positions, and the FSM state enum.
REQ-028 One sub-module, s2_cfg_shreg: a parameterised shift register with a shift-enable input and a synchronous clear.
REQ-029 The FSM, counter and parity accumulator live in s2_cfg_loader.

Verification (NCELL=2)
REQ-030 Pass load: start, then bits of 16'hA53C MSB-first (plus parity 0 if compiled in) -> cfg_out=16'hA53C, cfg_we=1 and done=1 for one cycle, err=0.
REQ-031 Parity fail (S2_CFG_PARITY_EN defined): previous load 16'hA53C, then 16'h0001 with parity 0 -> done=1, err=1, cfg_we=0, cfg_out stays 16'hA53C.
REQ-032 Stall: bit_valid dropped for 5 cycles mid-stream -> busy stays 1 and the result is identical to the pass load.
REQ-033 Reset mid-load: clr after 7 bits -> next cycle busy=0, cfg_out=0; a fresh start with 16'hFF00 loads 16'hFF00.
REQ-034 Ignored inputs: start pulsed during LOAD and bit_valid pulsed in IDLE -> no state change, and the bit count is unaffected.
